// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and line levels.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic START_LVL      = 1'b0;
  localparam logic STOP_LVL       = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the transmitter. Pushes while full and
// pops while empty are ignored; full/empty derive from a registered count.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 framing, LSB first, fed from a small byte FIFO.
// The line is driven from a register whose next value follows the next state.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Tx_DV_in,
  input  logic [UART_DATA_BITS-1:0] Tx_Byte_in,
  output logic                      Tx_Ready_out,
  output logic                      Tx_Serial_out,
  output logic                      Tx_Active_out,
  output logic                      Tx_Done_out
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]    CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_t               state, state_n;
  logic [CW-1:0]             clk_cnt, cnt_n;
  logic [IDX_W-1:0]          bit_idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
  logic                      line, line_n;
  logic                      cnt_last;

  logic                      fifo_full, fifo_empty, pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_BITS)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (Tx_DV_in),
    .din   (Tx_Byte_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_last      = (clk_cnt == CNT_MAX);
  assign Tx_Ready_out  = ~fifo_full;
  assign Tx_Serial_out = line;
  assign Tx_Active_out = (state != IDLE);
  assign Tx_Done_out   = (state == STOP) && cnt_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      line      <= STOP_LVL;
    end else begin
      state     <= state_n;
      clk_cnt   <= cnt_n;
      bit_idx   <= idx_n;
      shift_reg <= shift_n;
      line      <= line_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = clk_cnt;
    idx_n   = bit_idx;
    shift_n = shift_reg;
    line_n  = line;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        line_n = STOP_LVL;
        if (!fifo_empty) begin
          // Byte is captured here so later input changes cannot touch this frame.
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = '0;
          idx_n   = '0;
          line_n  = START_LVL;
          state_n = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          line_n  = shift_reg[0];
          state_n = DATA;
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_idx == LAST_IDX) begin
            line_n  = STOP_LVL;
            state_n = STOP;
          end else begin
            idx_n  = bit_idx + 1'b1;
            line_n = shift_reg[idx_n];
          end
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          line_n  = STOP_LVL;
          state_n = IDLE;
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      default: begin
        line_n  = STOP_LVL;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line monitor decodes each frame cycle by cycle
// and compares it against a scoreboard of bytes queued as they are pushed.
module tb_uart_transmitter;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       Tx_DV_in = 1'b0;
  logic [7:0] Tx_Byte_in = 8'h00;
  logic       Tx_Ready_out, Tx_Serial_out, Tx_Active_out, Tx_Done_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_seen = 0;
  int         last_start = 0;
  int         last_done = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .Tx_DV_in      (Tx_DV_in),
    .Tx_Byte_in    (Tx_Byte_in),
    .Tx_Ready_out  (Tx_Ready_out),
    .Tx_Serial_out (Tx_Serial_out),
    .Tx_Active_out (Tx_Active_out),
    .Tx_Done_out   (Tx_Done_out)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Line monitor: frame = start(0), 8 data LSB first, stop(1), CPB cycles each.
  logic       m_ok, m_abort, m_have;
  logic [7:0] m_exp, m_got;
  logic [9:0] m_fr;
  always begin : line_monitor
    @(negedge CLK);
    if (RST_N && Tx_Serial_out === 1'b0) begin
      m_ok    = 1'b1;
      m_abort = 1'b0;
      m_got   = 8'h00;
      m_have  = (exp_q.size() != 0);
      m_exp   = m_have ? exp_q.pop_front() : 8'h00;
      m_fr    = {1'b1, m_exp, 1'b0};
      frames_seen++;
      last_start = cyc;
      start_q.push_back(cyc);
      for (int b = 0; b < 10 && !m_abort; b++)
        for (int c = 0; c < CPB && !m_abort; c++) begin
          if (b != 0 || c != 0) @(negedge CLK);
          if (!RST_N) m_abort = 1'b1;
          else begin
            if (Tx_Done_out === 1'b1) last_done = cyc;
            if (b >= 1 && b <= 8 && c == CPB/2) m_got[b-1] = Tx_Serial_out;
            if (Tx_Active_out !== 1'b1) m_ok = 1'b0;
            if (Tx_Done_out !== (b == 9 && c == CPB-1)) m_ok = 1'b0;
            if (Tx_Serial_out !== m_fr[b]) m_ok = 1'b0;
          end
        end
      if (!m_abort) begin
        checks++;
        if (!m_have) begin
          errors++;
          $display("FAIL unexpected_frame got=%h expected=none", m_got);
        end else begin
          if (m_got !== m_exp) begin
            errors++;
            $display("FAIL rx_byte got=%h expected=%h", m_got, m_exp);
          end
          checks++;
          if (!m_ok) begin
            errors++;
            $display("FAIL frame_shape byte=%h start=%0d got=bad_waveform expected=clean_frame", m_exp, last_start);
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int acc);
    int n = 0;
    while (Tx_Ready_out !== 1'b1 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL push_wait_ready got=timeout expected=ready");
    end
    Tx_DV_in   = 1'b1;
    Tx_Byte_in = b;
    exp_q.push_back(b);
    @(negedge CLK);
    acc        = cyc;
    Tx_DV_in   = 1'b0;
    Tx_Byte_in = 8'hxx;
  endtask

  task automatic wait_idle;
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(exp_q.size() == 0 && Tx_Active_out === 1'b0) && n < 4000);
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got=timeout expected=idle");
    end
  endtask

  task automatic test_reset;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Tx_Serial_out !== 1'b1) begin errors++; $display("FAIL reset_line got=%b expected=1", Tx_Serial_out); end
    checks++; if (Tx_Ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b expected=1", Tx_Ready_out); end
    checks++; if (Tx_Active_out !== 1'b0) begin errors++; $display("FAIL reset_active got=%b expected=0", Tx_Active_out); end
    checks++; if (Tx_Done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", Tx_Done_out); end
    #2 RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++; if (Tx_Serial_out !== 1'b1 || Tx_Active_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got=line%b/active%b expected=line1/active0", Tx_Serial_out, Tx_Active_out);
    end
  endtask

  task automatic test_single;
    int acc, n;
    n = frames_seen;
    push_byte(8'hA5, acc);
    wait_idle();
    checks++; if (frames_seen !== n + 1) begin errors++; $display("FAIL single_frames got=%0d expected=%0d", frames_seen - n, 1); end
    checks++; if (last_start - acc !== 1) begin errors++; $display("FAIL single_latency got=%0d expected=1", last_start - acc); end
    checks++; if (last_done - last_start !== 10*CPB - 1) begin errors++; $display("FAIL single_done_cycle got=%0d expected=%0d", last_done - last_start, 10*CPB - 1); end
  endtask

  // The first byte is popped straight away, so the FIFO fills on the fifth push.
  task automatic test_back_to_back;
    logic [7:0] seq [5];
    int acc;
    seq = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C};
    start_q.delete();
    for (int i = 0; i < 5; i++) push_byte(seq[i], acc);
    checks++; if (Tx_Ready_out !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b expected=0", Tx_Ready_out); end
    // Pushes while full must be dropped; a stray 0x99 frame would be flagged by the monitor.
    Tx_DV_in = 1'b1; Tx_Byte_in = 8'h99;
    repeat (3) @(negedge CLK);
    Tx_DV_in = 1'b0; Tx_Byte_in = 8'hxx;
    checks++; if (Tx_Ready_out !== 1'b0) begin errors++; $display("FAIL drop_ready got=%b expected=0", Tx_Ready_out); end
    wait_idle();
    repeat (CPB*12) @(negedge CLK);
    checks++; if (start_q.size() !== 5) begin errors++; $display("FAIL b2b_frames got=%0d expected=5", start_q.size()); end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] !== 10*CPB + 1) begin
        errors++; $display("FAIL b2b_period idx=%0d got=%0d expected=%0d", i, start_q[i] - start_q[i-1], 10*CPB + 1);
      end
    end
  endtask

  task automatic test_simul_push_pop;
    int acc, n;
    push_byte(8'h10, acc);
    push_byte(8'h20, acc);
    push_byte(8'h30, acc);
    push_byte(8'h40, acc);
    checks++; if (Tx_Ready_out !== 1'b1) begin errors++; $display("FAIL simul_pre_ready got=%b expected=1", Tx_Ready_out); end
    n = 0;
    while (Tx_Done_out !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
    if (n >= 400) begin checks++; errors++; $display("FAIL simul_wait_done got=timeout expected=done"); end
    @(negedge CLK);
    push_byte(8'h50, acc);
    checks++; if (Tx_Ready_out !== 1'b1) begin errors++; $display("FAIL simul_ready got=%b expected=1", Tx_Ready_out); end
    checks++; if (Tx_Active_out !== 1'b1) begin errors++; $display("FAIL simul_popped got=%b expected=1", Tx_Active_out); end
    push_byte(8'h60, acc);
    checks++; if (Tx_Ready_out !== 1'b0) begin errors++; $display("FAIL simul_then_full got=%b expected=0", Tx_Ready_out); end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame;
    int acc, n;
    n = frames_seen;
    push_byte(8'h81, acc);
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    while (frames_seen == n && acc < 1000) begin @(negedge CLK); acc++; end
    repeat (3*CPB - 4) @(negedge CLK);
    checks++; if (Tx_Serial_out !== 1'b0) begin errors++; $display("FAIL mid_pre_line got=%b expected=0", Tx_Serial_out); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (Tx_Serial_out !== 1'b1) begin errors++; $display("FAIL mid_reset_line got=%b expected=1", Tx_Serial_out); end
    checks++; if (Tx_Active_out !== 1'b0) begin errors++; $display("FAIL mid_reset_active got=%b expected=0", Tx_Active_out); end
    exp_q.delete();
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b1;
    n = frames_seen;
    repeat (400) @(negedge CLK);
    checks++; if (frames_seen !== n) begin errors++; $display("FAIL mid_no_frame got=%0d expected=0", frames_seen - n); end
    checks++; if (Tx_Serial_out !== 1'b1 || Tx_Ready_out !== 1'b1) begin
      errors++; $display("FAIL mid_after_idle got=line%b/ready%b expected=line1/ready1", Tx_Serial_out, Tx_Ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
